// File: rtl/music_pkg.sv
// Shared definitions for the music and sound-effect players: FSM states, track ids and the
// game-status to track mapping.
package music_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} player_state_e;

  typedef logic [1:0] track_id_t;

  localparam track_id_t TRACK_SILENT = 2'd0;
  localparam track_id_t TRACK_1      = 2'd1;
  localparam track_id_t TRACK_2      = 2'd2;
  localparam track_id_t TRACK_3      = 2'd3;

  function automatic track_id_t status_to_track(input logic [3:0] status);
    case (status)
      4'd1, 4'd2, 4'd5: return TRACK_1;
      4'd4:             return TRACK_2;
      4'd3:             return TRACK_3;
      default:          return TRACK_SILENT;
    endcase
  endfunction

endpackage

// File: rtl/sample_rate_divider.sv
// Free-running sample-rate divider: one-cycle tick every TICK_DIV enabled cycles.
module sample_rate_divider #(
  parameter int unsigned TICK_DIV = 1134
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Gated by enable so a paused divider never ticks while frozen on its last count.
  assign tick = enable && (cnt_q == CntMax);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/music_stream_player.sv
// Music ROM reader: steps the shared ROM address at the sample rate, captures the selected
// track's sample and offers it to the serializer over valid/ready.
module music_stream_player
  import music_pkg::*;
#(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned SAMPLE_W  = 17,
  parameter int unsigned TRACK_LEN = 65536,
  parameter int unsigned TICK_DIV  = 1134
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [3:0]          status,
  input  logic                play_en,
  output logic [ADDR_W-1:0]   Add,
  input  logic [SAMPLE_W-1:0] rom1_q,
  input  logic [SAMPLE_W-1:0] rom2_q,
  input  logic [SAMPLE_W-1:0] rom3_q,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                loop_pulse,
  output logic [7:0]          miss_cnt
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(TRACK_LEN - 1);

  player_state_e       state_q;
  track_id_t           track_q;
  track_id_t           track_d;
  logic                tick;
  logic [SAMPLE_W-1:0] rom_sel;

  sample_rate_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_divider (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .enable  (play_en),
    .tick    (tick)
  );

  assign track_d = status_to_track(status);

  always_comb begin
    rom_sel = '0;
    case (track_q)
      TRACK_1: rom_sel = rom1_q;
      TRACK_2: rom_sel = rom2_q;
      TRACK_3: rom_sel = rom3_q;
      default: rom_sel = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      track_q      <= TRACK_SILENT;
      Add          <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      loop_pulse   <= 1'b0;
      miss_cnt     <= '0;
    end else begin
      track_q    <= track_d;
      loop_pulse <= 1'b0;
      if (tick && (state_q != IDLE) && (miss_cnt != 8'hFF)) begin
        miss_cnt <= miss_cnt + 8'd1;
      end
      // A track change restarts from word 0; dropping valid also covers an accepted transfer.
      if (track_d != track_q) begin
        Add          <= '0;
        state_q      <= IDLE;
        sample_valid <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (tick) state_q <= WAIT;
          end
          WAIT: begin
            sample_data  <= rom_sel;
            sample_valid <= 1'b1;
            state_q      <= HOLD;
            if (Add == LastAddr) begin
              Add        <= '0;
              loop_pulse <= 1'b1;
            end else begin
              Add <= Add + ADDR_W'(1);
            end
          end
          HOLD: begin
            if (sample_valid && sample_ready) begin
              sample_valid <= 1'b0;
              state_q      <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_stream_player.sv
// Directed bench for music_stream_player with TICK_DIV=8 and a 4-word track.
module tb_music_stream_player;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  status = 4'd0;
  logic        play_en = 1'b0;
  logic [16:0] Add;
  logic [16:0] rom1_q = '0;
  logic [16:0] rom2_q = '0;
  logic [16:0] rom3_q = '0;
  logic [16:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        loop_pulse;
  logic [7:0]  miss_cnt;

  logic [16:0] rom1 [0:3] = '{17'h00011, 17'h00022, 17'h00033, 17'h00044};
  logic [16:0] rom2 [0:3] = '{17'h10002, 17'h10012, 17'h10022, 17'h10032};
  logic [16:0] rom3 [0:3] = '{17'h0A003, 17'h0A013, 17'h0A023, 17'h0A033};

  int n_cmp = 0;
  int n_fail = 0;

  music_stream_player #(
    .ADDR_W    (17),
    .SAMPLE_W  (17),
    .TRACK_LEN (4),
    .TICK_DIV  (8)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .status       (status),
    .play_en      (play_en),
    .Add          (Add),
    .rom1_q       (rom1_q),
    .rom2_q       (rom2_q),
    .rom3_q       (rom3_q),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .loop_pulse   (loop_pulse),
    .miss_cnt     (miss_cnt)
  );

  always #5 Clk = ~Clk;

  // Registered ROMs with one-cycle read latency.
  always @(posedge Clk) begin
    rom1_q <= rom1[Add[1:0]];
    rom2_q <= rom2[Add[1:0]];
    rom3_q <= rom3[Add[1:0]];
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Release lands mid-cycle so the first edge after it is edge 1 with the divider at 0.
  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) step();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // Returns the number of edges taken until valid is seen, or -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (sample_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_valid: no sample_valid within 40 cycles (got timeout, want valid)");
    end
  endtask

  task automatic test_reset();
    status = 4'd1;
    play_en = 1'b1;
    sample_ready = 1'b1;
    Reset_n = 1'b0;
    #2;
    n_cmp++; if (Add !== 17'd0) begin n_fail++; $display("FAIL reset_add: got %h want 0", Add); end
    n_cmp++; if (sample_data !== 17'd0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", sample_data);
    end
    n_cmp++; if (sample_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", sample_valid);
    end
    n_cmp++; if (loop_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_loop: got %b want 0", loop_pulse);
    end
    n_cmp++; if (miss_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_miss: got %0d want 0", miss_cnt);
    end
  endtask

  task automatic test_basic();
    int n;
    logic [16:0] exp_data [0:4];
    exp_data = '{17'h00011, 17'h00022, 17'h00033, 17'h00044, 17'h00011};
    status = 4'd1; play_en = 1'b1; sample_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      n_cmp++; if (n !== ((i == 0) ? 9 : 7)) begin
        n_fail++; $display("FAIL basic_spacing[%0d]: got %0d edges want %0d", i, n,
                           (i == 0) ? 9 : 7);
      end
      n_cmp++; if (sample_data !== exp_data[i]) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, sample_data, exp_data[i]);
      end
      n_cmp++; if (Add !== 17'((i + 1) % 4)) begin
        n_fail++; $display("FAIL basic_add[%0d]: got %0d want %0d", i, Add, (i + 1) % 4);
      end
      n_cmp++; if (loop_pulse !== (i == 3)) begin
        n_fail++; $display("FAIL basic_loop[%0d]: got %b want %b", i, loop_pulse, i == 3);
      end
      step();
      n_cmp++; if (sample_valid !== 1'b0 || loop_pulse !== 1'b0) begin
        n_fail++; $display("FAIL basic_width[%0d]: got valid=%b loop=%b want 0/0", i,
                           sample_valid, loop_pulse);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad = 0;
    status = 4'd1; play_en = 1'b1; sample_ready = 1'b0;
    do_reset();
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      step();
      if (sample_valid !== 1'b1 || sample_data !== 17'h00011 || Add !== 17'd1) bad++;
    end
    n_cmp++; if (bad !== 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0 (data %h valid %b)", bad,
                         sample_data, sample_valid);
    end
    n_cmp++; if (miss_cnt !== 8'd2) begin
      n_fail++; $display("FAIL bp_miss: got %0d want 2", miss_cnt);
    end
    sample_ready = 1'b1;
    step();
    wait_valid(n);
    n_cmp++; if (sample_data !== 17'h00022 || Add !== 17'd2) begin
      n_fail++; $display("FAIL bp_next: got data %h add %0d want 00022 add 2", sample_data, Add);
    end
  endtask

  task automatic test_miss_saturate();
    int n;
    status = 4'd1; play_en = 1'b1; sample_ready = 1'b0;
    do_reset();
    wait_valid(n);
    repeat (260 * 8) step();
    n_cmp++; if (miss_cnt !== 8'd255) begin
      n_fail++; $display("FAIL miss_saturate: got %0d want 255", miss_cnt);
    end
  endtask

  task automatic test_track_switch();
    int n;
    status = 4'd1; play_en = 1'b1; sample_ready = 1'b0;
    do_reset();
    wait_valid(n);
    status = 4'd4;
    step();
    n_cmp++; if (sample_valid !== 1'b0 || Add !== 17'd0) begin
      n_fail++; $display("FAIL switch_drop: got valid=%b add=%0d want 0/0", sample_valid, Add);
    end
    sample_ready = 1'b1;
    wait_valid(n);
    n_cmp++; if (sample_data !== 17'h10002 || Add !== 17'd1) begin
      n_fail++; $display("FAIL switch_data: got %h add %0d want 10002 add 1", sample_data, Add);
    end
    status = 4'd3;
    step();
    wait_valid(n);
    n_cmp++; if (sample_data !== 17'h0A003) begin
      n_fail++; $display("FAIL switch_track3: got %h want 0a003", sample_data);
    end
  endtask

  task automatic test_silence();
    int n;
    status = 4'd0; play_en = 1'b1; sample_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      n_cmp++; if (sample_data !== 17'd0 || Add !== 17'((i + 1) % 4) || loop_pulse !== (i == 3))
      begin
        n_fail++; $display("FAIL silence[%0d]: got data %h add %0d loop %b want 0 %0d %b", i,
                           sample_data, Add, loop_pulse, (i + 1) % 4, i == 3);
      end
    end
  endtask

  task automatic test_pause();
    int n;
    int bad = 0;
    status = 4'd1; play_en = 1'b1; sample_ready = 1'b1;
    do_reset();
    wait_valid(n);
    wait_valid(n);
    step();
    play_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sample_valid !== 1'b0 || Add !== 17'd2) bad++;
    end
    n_cmp++; if (bad !== 0 || miss_cnt !== 8'd0) begin
      n_fail++; $display("FAIL pause_frozen: got %0d bad cycles miss %0d want 0/0", bad,
                         miss_cnt);
    end
    play_en = 1'b1;
    wait_valid(n);
    n_cmp++; if (n !== 7) begin
      n_fail++; $display("FAIL pause_phase: got %0d edges want 7", n);
    end
    n_cmp++; if (sample_data !== 17'h00033 || Add !== 17'd3) begin
      n_fail++; $display("FAIL pause_resume: got %h add %0d want 00033 add 3", sample_data, Add);
    end
  endtask

  task automatic test_async_reset();
    int n;
    status = 4'd1; play_en = 1'b1; sample_ready = 1'b1;
    do_reset();
    wait_valid(n);
    repeat (7) step();
    // Now inside the second fetch's WAIT cycle.
    #2;
    Reset_n = 1'b0;
    #1;
    n_cmp++; if (Add !== 17'd0 || sample_data !== 17'd0 || sample_valid !== 1'b0 ||
                 loop_pulse !== 1'b0 || miss_cnt !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: got add %0d data %h valid %b loop %b miss %0d want 0",
                         Add, sample_data, sample_valid, loop_pulse, miss_cnt);
    end
    step();
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_valid(n);
    n_cmp++; if (n !== 9 || sample_data !== 17'h00011 || Add !== 17'd1) begin
      n_fail++; $display("FAIL async_restart: got %0d edges data %h add %0d want 9 00011 1", n,
                         sample_data, Add);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_miss_saturate();
    test_track_switch();
    test_silence();
    test_pause();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
